cv32e40p_print_uart_bridge: RTL and testbench

//  Buffered console path from the cv32e40p_subsystem print port (print_valid/print_wdata) to a UART TX pin.

---
 rtl/cv32e40p_print_uart_pkg.sv | 22 ++
 rtl/cv32e40p_print_fifo.sv | 61 ++++++
 rtl/cv32e40p_print_uart_bridge.sv | 148 ++++++++++++++
 tb/tb_cv32e40p_print_uart_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_print_uart_pkg.sv
// cv32e40p_print_uart_pkg
//   Shared types and helpers for the print-port-to-UART console bridge.
//   - tx_state_e    : transmitter FSM states
//   - DROP_CNT_W    : width of the saturating drop counter
//   - calc_divisor  : clock cycles per serial bit (integer divide)
package cv32e40p_print_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int calc_divisor(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/cv32e40p_print_fifo.sv
// cv32e40p_print_fifo
//   Synchronous FIFO buffering console bytes ahead of the UART transmitter.
//   A push while full is accepted when a pop happens in the same cycle.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset (pointers and level)
//     push, wdata    write request and data
//     pop, rdata     read request; rdata shows the head entry combinationally
//     full, empty    occupancy flags
//     level          entries currently held (0..DEPTH)
module cv32e40p_print_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A slot frees up this cycle if the head is being popped.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cv32e40p_print_uart_bridge.sv
// cv32e40p_print_uart_bridge
//   Buffered console path from the subsystem print port to a UART TX pin.
//   Bytes are queued in a FIFO, serialised LSB first with a configurable
//   frame, and bytes arriving while the FIFO is full are counted as drops.
//   Optional feature macro: PRINT_UART_PARITY_EN inserts a parity bit after
//   the data bits (sense chosen by PARITY_ODD).
//   Ports:
//     clk_i, rst_i    core clock, asynchronous active-high reset
//     print_valid_i   one-cycle strobe, byte available
//     print_wdata_i   print data, only [DATA_BITS-1:0] used
//     tx_o            UART serial out, idle high, driven from a flop
//     busy_o          FIFO non-empty or frame in progress
//     fifo_level_o    bytes currently held in the FIFO
//     drop_cnt_o      bytes discarded on a full FIFO, saturating
module cv32e40p_print_uart_bridge
    import cv32e40p_print_uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          print_valid_i,
    input  logic [31:0]                   print_wdata_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

    localparam int DIVISOR = calc_divisor(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    if (DIVISOR < 2) begin : g_bad_divisor
        $fatal(1, "cv32e40p_print_uart_bridge: DIVISOR must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "cv32e40p_print_uart_bridge: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $fatal(1, "cv32e40p_print_uart_bridge: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "cv32e40p_print_uart_bridge: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state;
    tx_state_e            state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic                 bit_tick;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 tx_next;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 unused_wdata;

    assign unused_wdata = ^print_wdata_i[31:DATA_BITS];

    cv32e40p_print_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (print_valid_i),
        .wdata (print_wdata_i[DATA_BITS-1:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    assign fifo_pop = (state == IDLE) & ~fifo_empty;
    assign bit_tick = (baud_cnt == CNT_W'(DIVISOR - 1));
    assign busy_o   = (fifo_level_o != '0) | (state != IDLE);

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_tick && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef PRINT_UART_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            // Only reachable when the parity feature is built in.
            PARITY: begin
                tx_next = parity_bit;
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                if (bit_tick && bit_idx == 3'(STOP_BITS - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx_o       <= 1'b1;
            drop_cnt_o <= '0;
        end else begin
            state <= state_next;
            tx_o  <= tx_next;
            // Held at zero while idle so every frame starts with a full bit period.
            if (state == IDLE || bit_tick) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;
            if (state_next != state) bit_idx <= '0;
            else if (bit_tick)       bit_idx <= bit_idx + 1'b1;
            if (print_valid_i && fifo_full && !fifo_pop && drop_cnt_o != '1)
                drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_pop) begin
            shift_reg  <= fifo_rdata;
            parity_bit <= (^fifo_rdata) ^ PARITY_ODD[0];
        end else if (state == DATA && bit_tick) begin
            shift_reg  <= shift_reg >> 1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_print_uart_bridge.sv
module tb_cv32e40p_print_uart_bridge;

    localparam int CLOCK_RATE = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int D          = CLOCK_RATE / BAUD_RATE;
`ifdef PRINT_UART_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 1 + DATA_BITS + PBITS + STOP_BITS;
    localparam int L     = D * NBITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        print_valid = 1'b0;
    logic [31:0] print_wdata = '0;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;

    cv32e40p_print_uart_bridge #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .print_valid_i (print_valid),
        .print_wdata_i (print_wdata),
        .tx_o          (tx),
        .busy_o        (busy),
        .fifo_level_o  (fifo_level),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending bytes plus the start edge of the
    // frame on the wire; the expected line level is looked up from the frame's
    // bit list by elapsed time.
    int   q[$];
    int   edge_n = 0;
    int   t_s = 0;
    bit   have_frame = 0;
    logic frame_bits [NBITS];
    int   drop_m = 0;
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;
    int   exp_level = 0;

    task automatic model_reset();
        q.delete();
        have_frame = 0;
        drop_m     = 0;
        exp_tx     = 1'b1;
        exp_busy   = 1'b0;
        exp_level  = 0;
    endtask

    task automatic model_update(input bit v, input logic [7:0] d);
        int sz0;
        bit pop;
        int k;
        int b;
        int ones;
        edge_n++;
        sz0 = q.size();
        pop = (sz0 > 0) && (!have_frame || edge_n > t_s + L);
        if (pop) begin
            b          = q.pop_front();
            t_s        = edge_n;
            have_frame = 1;
            ones       = 0;
            frame_bits[0] = 1'b0;
            for (int i = 0; i < DATA_BITS; i++) begin
                frame_bits[1 + i] = b[i];
                ones += b[i];
            end
`ifdef PRINT_UART_PARITY_EN
            frame_bits[1 + DATA_BITS] = ((ones % 2) != PARITY_ODD);
`endif
            for (int i = 0; i < STOP_BITS; i++) frame_bits[1 + DATA_BITS + PBITS + i] = 1'b1;
        end
        if (v) begin
            if (sz0 < FIFO_DEPTH || pop) q.push_back(int'(d) & ((1 << DATA_BITS) - 1));
            else if (drop_m < 65535) drop_m++;
        end
        k         = edge_n - t_s;
        exp_level = q.size();
        exp_tx    = (have_frame && k >= 1 && k <= L) ? frame_bits[(k - 1) / D] : 1'b1;
        exp_busy  = (q.size() != 0) || (have_frame && k < L);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [7:0] d);
        logic [31:0] junk;
        junk        = $urandom();
        print_valid = v;
        print_wdata = {junk[31:8], d};
        @(posedge clk);
        model_update(v, d);
        @(negedge clk);
        print_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        step(1, 8'h41);
        for (int c = 0; c < L + 10; c++) begin
            step(0, 8'h00);
            if (tx !== exp_tx) begin errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", edge_n, busy, exp_busy); end
            checks++;
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        checks++;
    endtask

    task automatic test_three_frames();
        logic [7:0] bytes [3];
        int peak;
        bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h0F;
        peak = 0;
        for (int c = 0; c < 3 * (L + 1) + 10; c++) begin
            step(c < 3, (c < 3) ? bytes[c] : 8'h00);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (tx !== exp_tx) begin errors++; $display("FAIL three_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (fifo_level !== 3'(exp_level)) begin errors++; $display("FAIL three_level cyc=%0d got=%0d exp=%0d", edge_n, fifo_level, exp_level); end
            checks++;
        end
        if (peak !== 2) begin errors++; $display("FAIL three_peak got=%0d exp=2", peak); end
        checks++;
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 5 * (L + 1) + 10; c++) begin
            step(c < 8, 8'(8'h30 + c));
            if (tx !== exp_tx) begin errors++; $display("FAIL ovf_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (drop_cnt !== 16'(drop_m)) begin errors++; $display("FAIL ovf_drop cyc=%0d got=%0d exp=%0d", edge_n, drop_cnt, drop_m); end
            checks++;
            if (c == 8 && fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_full got=%0d exp=4", fifo_level); end
            if (c == 8) checks++;
        end
        if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop_total got=%0d exp=3", drop_cnt); end
        checks++;
    endtask

    task automatic test_push_pop_full();
        logic [15:0] drop_before;
        for (int c = 0; c < 5; c++) step(1, 8'(8'hC0 + c));
        for (int c = 0; c < 2000 && edge_n != t_s + L; c++) begin
            step(0, 8'h00);
            if (tx !== exp_tx) begin errors++; $display("FAIL ppf_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
        end
        if (edge_n != t_s + L) begin errors++; $display("FAIL ppf_wait timeout got=%0d exp=%0d", edge_n, t_s + L); end
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL ppf_level_before got=%0d exp=4", fifo_level); end
        checks++;
        drop_before = drop_cnt;
        step(1, 8'hE7);
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL ppf_level_after got=%0d exp=4", fifo_level); end
        checks++;
        if (drop_cnt !== drop_before || drop_cnt !== 16'(drop_m)) begin
            errors++; $display("FAIL ppf_drop got=%0d exp=%0d", drop_cnt, drop_m);
        end
        checks++;
        for (int c = 0; c < 5 * (L + 1) + 10; c++) begin
            step(0, 8'h00);
            if (tx !== exp_tx) begin errors++; $display("FAIL ppf_drain_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL ppf_drain_busy cyc=%0d got=%b exp=%b", edge_n, busy, exp_busy); end
            checks++;
        end
    endtask

    task automatic test_reset_midframe();
        step(1, 8'h41);
        step(1, 8'h42);
        // Elapsed 1+D*4 .. D*5 after the pop is data bit 3 on the line.
        for (int c = 0; c < 200 && (edge_n - t_s) < 4 * D + 5; c++) step(0, 8'h00);
        if (tx !== exp_tx || exp_tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx got=%b exp=%b", tx, exp_tx); end
        checks++;
        rst = 1'b1;
        #1;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got=%0d exp=0", fifo_level); end
        checks++;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_drop got=%0d exp=0", drop_cnt); end
        checks++;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 8'h41);
        for (int c = 0; c < L + 10; c++) begin
            step(0, 8'h00);
            if (tx !== exp_tx) begin errors++; $display("FAIL mid_after_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL mid_after_busy cyc=%0d got=%b exp=%b", edge_n, busy, exp_busy); end
            checks++;
        end
    endtask

    task automatic test_random();
        bit   v;
        logic [7:0] d;
        for (int c = 0; c < 1500 + 6 * (L + 1); c++) begin
            v = (c < 1500) && ($urandom_range(0, 2) == 0);
            d = 8'($urandom());
            step(v, d);
            if (tx !== exp_tx) begin errors++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", edge_n, tx, exp_tx); end
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", edge_n, busy, exp_busy); end
            checks++;
            if (fifo_level !== 3'(exp_level)) begin errors++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", edge_n, fifo_level, exp_level); end
            checks++;
            if (drop_cnt !== 16'(drop_m)) begin errors++; $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", edge_n, drop_cnt, drop_m); end
            checks++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_three_frames();
        test_overflow();
        test_push_pop_full();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
